// File: rtl/bvci_simple_initiator.sv
// BVCI initiator: turns a request/stream interface into BVCI command cells and
// collects response cells. One transaction in flight, incrementing bursts only.
module bvci_simple_initiator #(
    parameter int aw      = 12,
    parameter int dw      = 32,
    parameter int MAX_LEN = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [aw-1:0]   req_addr,
    input  logic [4:0]      req_len,
    input  logic [dw/8-1:0] req_be,
    input  logic [dw-1:0]   wr_data,
    input  logic            wr_valid,
    output logic            wr_ready,
    output logic [dw-1:0]   rd_data,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic            done,
    output logic            done_err,
    output logic            cmdval,
    input  logic            cmdack,
    output logic [1:0]      cmd,
    output logic [aw-1:0]   address,
    output logic            wrap,
    output logic [7:0]      plen,
    output logic [dw-1:0]   wdata,
    output logic [dw/8-1:0] be,
    output logic            eop,
    input  logic            rspval,
    output logic            rspack,
    input  logic [dw-1:0]   rdata,
    input  logic            rerr,
    input  logic            reop
);
    localparam int BYTES = dw / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_RSP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            write_q, write_d;
    logic [aw-1:0]   addr_q, addr_d;
    logic [4:0]      len_q, len_d;
    logic [dw/8-1:0] be_q, be_d;
    logic [4:0]      cmd_cnt_q, cmd_cnt_d;
    logic [4:0]      rsp_cnt_q, rsp_cnt_d;
    logic            err_q, err_d;
    logic            stray_q, stray_d;

    logic            in_cmd, in_xfer, last_cmd, cmd_fire, rsp_fire, stray_now;
    logic [aw-1:0]   offset;

    always_comb begin
        in_cmd   = (state_q == S_CMD);
        in_xfer  = (state_q == S_CMD) || (state_q == S_RSP);
        last_cmd = (cmd_cnt_q == len_q - 5'd1);
        offset   = aw'(cmd_cnt_q) * aw'(BYTES);

        req_ready = (state_q == S_IDLE);
        cmdval    = in_cmd && (write_q ? wr_valid : 1'b1);
        cmd_fire  = cmdval && cmdack;
        wr_ready  = write_q && cmd_fire;
        cmd       = in_cmd ? (write_q ? 2'b10 : 2'b01) : 2'b00;
        address   = in_cmd ? addr_q + offset : '0;
        plen      = in_cmd ? 8'(len_q) * 8'(BYTES) : 8'd0;
        be        = in_cmd ? be_q : '0;
        wdata     = (in_cmd && write_q) ? wr_data : '0;
        eop       = in_cmd && last_cmd;
        wrap      = 1'b0;

        // Outside a transaction the response channel is drained unconditionally.
        rspack    = in_xfer ? (write_q ? 1'b1 : rd_ready) : 1'b1;
        rd_valid  = in_xfer && !write_q && rspval;
        rd_data   = rdata;
        rsp_fire  = rspval && rspack;
        stray_now = rspval && !in_xfer;

        done      = (state_q == S_DONE);
        done_err  = done && (err_q || stray_q);

        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        len_d     = len_q;
        be_d      = be_q;
        cmd_cnt_d = cmd_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        err_d     = err_q;
        stray_d   = (stray_q && !done) || stray_now;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d   = req_write;
                    addr_d    = req_addr;
                    if (req_len == 5'd0)
                        len_d = 5'd1;
                    else if (req_len > 5'(MAX_LEN))
                        len_d = 5'(MAX_LEN);
                    else
                        len_d = req_len;
                    be_d      = req_be;
                    cmd_cnt_d = 5'd0;
                    rsp_cnt_d = 5'd0;
                    err_d     = 1'b0;
                    state_d   = S_CMD;
                end
            end
            S_CMD: begin
                if (cmd_fire) begin
                    cmd_cnt_d = cmd_cnt_q + 5'd1;
                    if (last_cmd)
                        state_d = S_RSP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        // A reop cell completes only once every command cell is out (this cycle counts).
        if (in_xfer && rsp_fire) begin
            rsp_cnt_d = rsp_cnt_q + 5'd1;
            err_d     = err_d || rerr || (reop && (rsp_cnt_q != len_q - 5'd1));
            if (reop && ((state_q == S_RSP) || (cmd_fire && last_cmd)))
                state_d = S_DONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            addr_q    <= '0;
            len_q     <= 5'd0;
            be_q      <= '0;
            cmd_cnt_q <= 5'd0;
            rsp_cnt_q <= 5'd0;
            err_q     <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            be_q      <= be_d;
            cmd_cnt_q <= cmd_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            err_q     <= err_d;
            stray_q   <= stray_d;
        end
    end
endmodule

// File: tb/tb_bvci_simple_initiator.sv
// Directed bench for bvci_simple_initiator (aw=12, dw=32): inputs change one
// time unit after the rising edge, outputs are checked one unit later.
module tb_bvci_simple_initiator;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [11:0] req_addr;
    logic [4:0]  req_len;
    logic [3:0]  req_be;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic        done, done_err;
    logic        cmdval, cmdack;
    logic [1:0]  cmd;
    logic [11:0] address;
    logic        wrap;
    logic [7:0]  plen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        eop;
    logic        rspval, rspack;
    logic [31:0] rdata;
    logic        rerr, reop;

    int n_pass = 0;
    int n_total = 0;
    int wr_cnt;
    int beat;
    logic [6:0] pat;

    always #5 clock = ~clock;

    bvci_simple_initiator #(.aw(12), .dw(32), .MAX_LEN(16)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_be(req_be),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .done_err(done_err),
        .cmdval(cmdval), .cmdack(cmdack), .cmd(cmd), .address(address),
        .wrap(wrap), .plen(plen), .wdata(wdata), .be(be), .eop(eop),
        .rspval(rspval), .rspack(rspack), .rdata(rdata), .rerr(rerr), .reop(reop)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_req(input logic w, input logic [11:0] a, input logic [4:0] l,
                             input logic [3:0] b);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_be = b;
        #1;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic cmd_beat(input logic [11:0] a, input logic e);
        cmdack = 1'b1;
        #1;
        check("cmdval", 64'(cmdval), 64'd1);
        check("address", 64'(address), 64'(a));
        check("eop", 64'(e ? 1'b1 : 1'b0), 64'(eop));
        step();
        cmdack = 1'b0;
    endtask

    task automatic rsp_beat(input logic [31:0] d, input logic er, input logic last,
                            input logic is_read);
        rspval = 1'b1; rdata = d; rerr = er; reop = last;
        #1;
        check("rspack", 64'(rspack), 64'd1);
        check("rd_valid", 64'(rd_valid), 64'(is_read));
        if (is_read) check("rd_data", 64'(rd_data), 64'(d));
        step();
        rspval = 1'b0; rerr = 1'b0; reop = 1'b0;
    endtask

    task automatic check_done(input logic exp_err);
        #1;
        check("done", 64'(done), 64'd1);
        check("done_err", 64'(done_err), 64'(exp_err));
        step();
        check("req_ready_after", 64'(req_ready), 64'd1);
        check("done_low_after", 64'(done), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
        req_be = '0; wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b1; cmdack = 1'b0;
        rspval = 1'b0; rdata = '0; rerr = 1'b0; reop = 1'b0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_done_err", 64'(done_err), 64'd0);
        check("rst_cmdval", 64'(cmdval), 64'd0);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_eop", 64'(eop), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        check("rst_cmd", 64'(cmd), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_plen", 64'(plen), 64'd0);
        check("rst_be", 64'(be), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_rspack", 64'(rspack), 64'd1);

        // Single read
        issue_req(1'b0, 12'h010, 5'd1, 4'hF);
        cmdack = 1'b1;
        #1;
        check("rd1_cmd", 64'(cmd), 64'h1);
        check("rd1_plen", 64'(plen), 64'd4);
        check("rd1_eop", 64'(eop), 64'd1);
        check("rd1_be", 64'(be), 64'hF);
        check("rd1_addr", 64'(address), 64'h010);
        check("rd1_req_ready", 64'(req_ready), 64'd0);
        step();
        cmdack = 1'b0;
        rsp_beat(32'hDEADBEEF, 1'b0, 1'b1, 1'b1);
        check_done(1'b0);

        // 4-beat write with wr_valid gaps
        issue_req(1'b1, 12'h100, 5'd4, 4'hC);
        cmdack = 1'b1; beat = 0; wr_cnt = 0; pat = 7'b1100101;
        for (int i = 0; i < 7; i++) begin
            wr_valid = pat[i];
            wr_data = 32'hA000_0000 | 32'(beat);
            #1;
            wr_cnt += int'(wr_ready);
            if (pat[i]) begin
                check("wr_cmdval", 64'(cmdval), 64'd1);
                check("wr_addr", 64'(address), 64'(12'h100 + 12'(4 * beat)));
                check("wr_eop", 64'(eop), 64'(beat == 3));
                check("wr_wdata", 64'(wdata), 64'(32'hA000_0000 | 32'(beat)));
                check("wr_plen", 64'(plen), 64'd16);
                check("wr_cmd", 64'(cmd), 64'h2);
                check("wr_be", 64'(be), 64'hC);
                beat++;
            end else begin
                check("wr_gap_cmdval", 64'(cmdval), 64'd0);
            end
            step();
        end
        wr_valid = 1'b0; cmdack = 1'b0;
        check("wr_ready_pulses", 64'(wr_cnt), 64'd4);
        #1;
        check("wr_rsp_cmdval", 64'(cmdval), 64'd0);
        for (int i = 0; i < 4; i++) rsp_beat(32'h0, 1'b0, i == 3, 1'b0);
        check_done(1'b0);

        // cmdack stalled for 3 cycles mid-burst
        issue_req(1'b0, 12'h200, 5'd3, 4'hF);
        cmd_beat(12'h200, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_cmdval", 64'(cmdval), 64'd1);
            check("stall_addr", 64'(address), 64'h204);
            check("stall_eop", 64'(eop), 64'd0);
            check("stall_plen", 64'(plen), 64'd12);
            check("stall_cmd", 64'(cmd), 64'h1);
            step();
        end
        cmd_beat(12'h204, 1'b0);
        cmd_beat(12'h208, 1'b1);
        for (int i = 0; i < 3; i++) rsp_beat(32'h5500 + 32'(i), 1'b0, i == 2, 1'b1);
        check_done(1'b0);

        // Read burst of 4 with rerr on beat 2
        issue_req(1'b0, 12'h040, 5'd4, 4'hF);
        for (int i = 0; i < 4; i++) cmd_beat(12'h040 + 12'(4 * i), i == 3);
        for (int i = 0; i < 4; i++) rsp_beat(32'h7700 + 32'(i), i == 1, i == 3, 1'b1);
        check_done(1'b1);

        // Clean len-2 read; first response overlaps the last command cell
        issue_req(1'b0, 12'h060, 5'd2, 4'hF);
        cmd_beat(12'h060, 1'b0);
        cmdack = 1'b1; rspval = 1'b1; rdata = 32'h1234; reop = 1'b0;
        #1;
        check("ovl_addr", 64'(address), 64'h064);
        check("ovl_eop", 64'(eop), 64'd1);
        check("ovl_rd_valid", 64'(rd_valid), 64'd1);
        step();
        cmdack = 1'b0; rspval = 1'b0;
        rsp_beat(32'h5678, 1'b0, 1'b1, 1'b1);
        check_done(1'b0);

        // Address wrap
        issue_req(1'b0, 12'hFFC, 5'd2, 4'hF);
        cmd_beat(12'hFFC, 1'b0);
        cmd_beat(12'h000, 1'b1);
        rsp_beat(32'h1, 1'b0, 1'b0, 1'b1);
        rsp_beat(32'h2, 1'b0, 1'b1, 1'b1);
        check_done(1'b0);

        // Early reop on beat 1 of a len-3 read
        issue_req(1'b0, 12'h300, 5'd3, 4'hF);
        for (int i = 0; i < 3; i++) cmd_beat(12'h300 + 12'(4 * i), i == 2);
        rsp_beat(32'h9, 1'b0, 1'b1, 1'b1);
        check_done(1'b1);

        // Stray cell in IDLE is drained and reported on the next done; len 0 -> 1
        rspval = 1'b1; rdata = 32'hBAD;
        #1;
        check("stray_rspack", 64'(rspack), 64'd1);
        check("stray_rd_valid", 64'(rd_valid), 64'd0);
        step();
        rspval = 1'b0;
        issue_req(1'b0, 12'h020, 5'd0, 4'hF);
        cmdack = 1'b1;
        #1;
        check("len0_plen", 64'(plen), 64'd4);
        check("len0_eop", 64'(eop), 64'd1);
        step();
        cmdack = 1'b0;
        rsp_beat(32'h3, 1'b0, 1'b1, 1'b1);
        check_done(1'b1);
        issue_req(1'b0, 12'h024, 5'd1, 4'hF);
        cmd_beat(12'h024, 1'b1);
        rsp_beat(32'h4, 1'b0, 1'b1, 1'b1);
        check_done(1'b0);

        // Reset during CMD
        issue_req(1'b0, 12'h080, 5'd4, 4'hF);
        cmdack = 1'b0;
        #1;
        check("pre_rst_cmdval", 64'(cmdval), 64'd1);
        reset = 1'b1;
        step();
        check("mid_rst_cmdval", 64'(cmdval), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        step();
        check("post_rst_done", 64'(done), 64'd0);
        check("post_rst_cmdval", 64'(cmdval), 64'd0);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bvci_simple_initiator.md
# bvci_simple_initiator

BVCI initiator that turns a simple request/stream interface into BVCI command cells and collects the response cells. It is the initiator end of the same BVCI point-to-point link that our target blocks (including the dummy target) terminate, used by test masters and small DMA-style engines. One transaction is outstanding at a time: single or incrementing bursts of up to `MAX_LEN` beats.

## Interface
- `aw`, 12: BVCI address width.
- `dw`, 32: BVCI data width; 32 or 64 only.
- `MAX_LEN`, 16: maximum beats per request. `MAX_LEN*dw/8` must be ≤ 255.
- `clock` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: initiator idle and able to accept a request.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in aw: start byte address; must be `dw/8`-aligned.
- `req_len` in 5: beat count, 1..`MAX_LEN`. 0 is treated as 1.
- `req_be` in dw/8: byte enables applied to every beat.
- `wr_data` in dw: write-data stream.
- `wr_valid` in 1: write beat available.
- `wr_ready` out 1: write beat consumed this cycle.
- `rd_data` out dw: read-data beat.
- `rd_valid` out 1: read beat valid.
- `rd_ready` in 1: sink accepts the read beat.
- `done` out 1: one-cycle pulse when a transaction completes.
- `done_err` out 1: valid with `done`; transaction had an error.
- `cmdval` out 1: BVCI command valid.
- `cmdack` in 1: BVCI command accepted.
- `cmd` out 2: 2'b01 read, 2'b10 write.
- `address` out aw: BVCI address.
- `wrap` out 1: tied 0.
- `plen` out 8: burst length in bytes, `len*dw/8`.
- `wdata` out dw: write data.
- `be` out dw/8: byte enables.
- `eop` out 1: last command cell of the burst.
- `rspval` in 1: BVCI response valid.
- `rspack` out 1: BVCI response accepted.
- `rdata` in dw: response data.
- `rerr` in 1: response error.
- `reop` in 1: last response cell.

## Operation
- States: IDLE, CMD, RSP, DONE.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, latch write, addr, len (0→1), be. Clear beat counters and the error flag. Go to CMD.
- **CMD**
  - Read: `cmdval=1`. Write: `cmdval=wr_valid`; `wdata=wr_data`.
  - `cmd`, `plen` and `be` are constant for the whole burst.
  - `address = latched_addr + cmd_cnt*(dw/8)`, truncated to aw bits (wraps modulo 2^aw).
  - `eop = (cmd_cnt == len-1)`.
  - A beat is issued when `cmdval & cmdack`. It increments `cmd_cnt`. For writes, `wr_ready = cmdval & cmdack` that cycle.
  - After the `eop` cell is accepted, go to RSP.
- **Responses (CMD and RSP)**
  - Write transaction: `rspack=1`. Read transaction: `rspack=rd_ready`.
  - `rd_valid = rspval` (reads only), `rd_data = rdata`.
  - A cell is accepted when `rspval & rspack`. It increments `rsp_cnt` and ORs `rerr` into the error flag.
- **Protocol error:** `reop` on a cell where `rsp_cnt != len-1`, or `rspval` arriving after completion, sets the error flag.
  - A stray cell arriving in IDLE/DONE is acked (`rspack=1` there) and dropped.
  - The stray-cell error is reported on the next `done`.
- **Completion:** the accepted cell with `reop` moves the FSM to DONE. This happens from RSP, or from CMD only if all command cells are already accepted.
- **DONE:** `done=1`, `done_err = flag`; next state IDLE.
- **Reset:** at any state, returns to IDLE and drops any in-flight burst without a `done`.

## Timing
- **Reset values:**
  - `req_ready=1`; `done`, `done_err`, `cmdval`, `wr_ready`, `rd_valid`, `eop`, `wrap` = 0.
  - `cmd=0`, `address=0`, `plen=0`, `be=0`, `wdata=0`.
  - `rspack=1` (idle drain).
- **Request acceptance:** request accepted at edge N; `cmdval` can first be high in cycle N+1.
- **Command throughput:** one command cell per cycle with `cmdack` held high.
- **Command stability:** while `cmdval & !cmdack`, `cmd`, `address`, `plen`, `be`, `eop` and `wdata` hold.
  - For writes, `wr_data` must hold while `wr_valid & !wr_ready`. This is the upstream contract.
- **Response acceptance:** responses are accepted in the same cycle they are presented. No response is accepted before its request is latched.
- **Done latency:**
  - `done` pulses in the cycle after the `reop` cell is accepted.
  - `req_ready` returns the cycle after `done`.
  - Minimum single-beat transaction, with `cmdack` and `rspval` immediate: request N, cmd N+1, rsp N+2, `done` N+3.
- **Concurrency:** a response cell and a command cell may be accepted in the same cycle. Both counters update.

## Test plan
- **Single read:** `req_addr=0x010`, len 1, target acks immediately and returns `rdata=0xDEADBEEF` with `reop` one cycle later.
  - Required: `cmd=01`, `plen=4`, `eop=1`.
  - Required: `rd_valid` with `0xDEADBEEF`; `done=1`, `done_err=0`.
- **4-beat write, `wr_valid` gaps, dw=32, addr 0x100:**
  - Required: addresses 0x100, 0x104, 0x108, 0x10C; `plen=16`; `eop` only on the 4th cell.
  - Required: `cmdval` low in gap cycles; exactly 4 `wr_ready` pulses.
- **`cmdack` low for 3 cycles mid-burst:** all command fields hold stable and the `cmd_cnt` value is not skipped.
- **Read burst len 4, `rerr` on beat 2:** all 4 beats delivered; `done_err=1`.
  - Next clean read of len 2 gives `done_err=0`.
- **Address wrap:** `aw=12`, addr 0xFFC, len 2. Required addresses 0xFFC then 0x000.
- **Early `reop` and reset mid-burst:**
  - `reop` on beat 1 of a len-3 read gives `done` with `done_err=1`.
  - `reset` asserted during CMD gives, the next cycle, `cmdval=0`, `req_ready=1` and no `done`.
